// File: rtl/bus_port_fifo.sv
// bus_port_fifo: per-port TX/RX packet FIFOs between a host and the bus arbiter
module bus_port_fifo_buf #(
  parameter int width = 16,
  parameter int depth = 8,
  parameter int cnt_w = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr,
  input  logic [width-1:0]           wdata,
  input  logic                       rd,
  output logic [width-1:0]           rdata,
  output logic [$clog2(depth):0]     count,
  output logic [cnt_w-1:0]           drop_cnt
);
  localparam int aw = $clog2(depth);
  logic [width-1:0] mem [depth];
  logic [aw-1:0] wr_ptr, rd_ptr;
  logic rd_ok, wr_ok, full, empty;
  assign empty = count == '0;
  assign full  = count == (aw+1)'(depth);
  assign rd_ok = rd && !empty;
  // a read in the same cycle frees the slot the write lands in
  assign wr_ok = wr && (!full || rd_ok);
  assign rdata = empty ? '0 : mem[rd_ptr];
  always_ff @(posedge clk)
    if (wr_ok && !reset) mem[wr_ptr] <= wdata;
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      drop_cnt <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (aw+1)'(wr_ok) - (aw+1)'(rd_ok);
      if (wr && !wr_ok && drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
    end
  end
endmodule

module bus_port_fifo #(
  parameter int pckg_sz = 16,
  parameter int depth   = 8,
  parameter int cnt_w   = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [pckg_sz-1:0]       wr_data,
  output logic                     tx_full,
  output logic [$clog2(depth):0]   tx_count,
  output logic                     pndng,
  output logic [pckg_sz-1:0]       D_pop,
  input  logic                     pop,
  input  logic                     push,
  input  logic [pckg_sz-1:0]       D_push,
  output logic                     rx_pndng,
  output logic [pckg_sz-1:0]       rx_data,
  input  logic                     rd_en,
  output logic [cnt_w-1:0]         tx_drop_cnt,
  output logic [cnt_w-1:0]         rx_drop_cnt,
  output logic                     pop_err
);
  logic [$clog2(depth):0] rx_count;
  bus_port_fifo_buf #(.width(pckg_sz), .depth(depth), .cnt_w(cnt_w)) u_tx (
    .clk(clk), .reset(reset), .wr(wr_en), .wdata(wr_data), .rd(pop),
    .rdata(D_pop), .count(tx_count), .drop_cnt(tx_drop_cnt)
  );
  bus_port_fifo_buf #(.width(pckg_sz), .depth(depth), .cnt_w(cnt_w)) u_rx (
    .clk(clk), .reset(reset), .wr(push), .wdata(D_push), .rd(rd_en),
    .rdata(rx_data), .count(rx_count), .drop_cnt(rx_drop_cnt)
  );
  assign pndng    = tx_count != '0;
  assign rx_pndng = rx_count != '0;
  assign tx_full  = tx_count == ($clog2(depth)+1)'(depth);
  always_ff @(posedge clk) begin
    if (reset) pop_err <= 1'b0;
    else if (pop && !pndng) pop_err <= 1'b1;
  end
endmodule

// File: tb/tb_bus_port_fifo.sv
// tb_bus_port_fifo: directed stimulus with queue scoreboard checked by a separate monitor
module tb_bus_port_fifo;
  logic clk = 0, reset = 1, wr_en = 0, pop = 0, push = 0, rd_en = 0;
  logic [15:0] wr_data = 0, D_push = 0;
  logic tx_full, pndng, rx_pndng, pop_err;
  logic [3:0] tx_count;
  logic [15:0] D_pop, rx_data;
  logic [7:0] tx_drop_cnt, rx_drop_cnt;
  int tests = 0, fails = 0;
  logic [15:0] tx_q[$], rx_q[$];

  bus_port_fifo dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .tx_full(tx_full),
    .tx_count(tx_count), .pndng(pndng), .D_pop(D_pop), .pop(pop), .push(push),
    .D_push(D_push), .rx_pndng(rx_pndng), .rx_data(rx_data), .rd_en(rd_en),
    .tx_drop_cnt(tx_drop_cnt), .rx_drop_cnt(rx_drop_cnt), .pop_err(pop_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!reset && pop && pndng) begin
      if (tx_q.size() == 0) chk("tx_unexpected_pop", 32'(D_pop), 32'hdead);
      else chk("tx_data", 32'(D_pop), 32'(tx_q.pop_front()));
    end
    if (!reset && rd_en && rx_pndng) begin
      if (rx_q.size() == 0) chk("rx_unexpected_read", 32'(rx_data), 32'hdead);
      else chk("rx_data", 32'(rx_data), 32'(rx_q.pop_front()));
    end
  end

  task automatic tx_write(input logic [15:0] d, input bit accepted);
    wr_en = 1; wr_data = d;
    if (accepted) tx_q.push_back(d);
    tick();
    wr_en = 0;
  endtask

  task automatic tx_pop(input int n);
    pop = 1;
    repeat (n) tick();
    pop = 0;
  endtask

  task automatic rx_push(input logic [15:0] d, input bit accepted);
    push = 1; D_push = d;
    if (accepted) rx_q.push_back(d);
    tick();
    push = 0;
  endtask

  task automatic rx_read(input int n);
    rd_en = 1;
    repeat (n) tick();
    rd_en = 0;
  endtask

  initial begin
    repeat (2) tick();
    reset = 0;
    tick();
    chk("rst_pndng", 32'(pndng), 0);
    chk("rst_D_pop", 32'(D_pop), 0);
    chk("rst_tx_count", 32'(tx_count), 0);
    chk("rst_tx_full", 32'(tx_full), 0);
    chk("rst_rx_pndng", 32'(rx_pndng), 0);
    chk("rst_rx_data", 32'(rx_data), 0);
    chk("rst_drops", 32'({tx_drop_cnt, rx_drop_cnt}), 0);
    chk("rst_pop_err", 32'(pop_err), 0);

    tx_write(16'h02AA, 1);
    chk("w1_pndng", 32'(pndng), 1);
    chk("w1_D_pop", 32'(D_pop), 32'h02AA);
    chk("w1_count", 32'(tx_count), 1);
    tx_pop(1);
    chk("p1_pndng", 32'(pndng), 0);

    for (int i = 0; i < 8; i++) tx_write(16'h0100 + 16'(i), 1);
    chk("fill_full", 32'(tx_full), 1);
    chk("fill_count", 32'(tx_count), 8);
    tx_pop(3);
    chk("pop3_count", 32'(tx_count), 5);
    chk("pop3_head", 32'(D_pop), 32'h0103);
    for (int i = 8; i < 11; i++) tx_write(16'h0100 + 16'(i), 1);
    chk("wrap_full", 32'(tx_full), 1);
    tx_pop(8);
    chk("wrap_drained", 32'(pndng), 0);

    for (int i = 0; i < 8; i++) tx_write(16'h0200 + 16'(i), 1);
    wr_en = 1; pop = 1; wr_data = 16'h0555; tx_q.push_back(16'h0555);
    tick();
    wr_en = 0; pop = 0;
    chk("sim_count", 32'(tx_count), 8);
    chk("sim_drop", 32'(tx_drop_cnt), 0);
    tx_write(16'h0666, 0);
    chk("full_drop", 32'(tx_drop_cnt), 1);
    chk("full_count", 32'(tx_count), 8);
    tx_pop(8);
    chk("sim_drained", 32'(pndng), 0);

    for (int i = 0; i < 10; i++) rx_push(16'hFF00 + 16'(i), i < 8);
    chk("rx_drop2", 32'(rx_drop_cnt), 2);
    chk("rx_head", 32'(rx_data), 32'hFF00);
    rx_read(8);
    chk("rx_drained", 32'(rx_pndng), 0);
    for (int i = 0; i < 300; i++) rx_push(16'hFE00 + 16'(i), i < 8);
    chk("rx_drop_sat", 32'(rx_drop_cnt), 32'hFF);
    rx_read(8);
    rx_read(1);
    chk("rx_empty_read", 32'(rx_pndng), 0);

    tx_pop(1);
    chk("perr_set", 32'(pop_err), 1);
    chk("perr_count", 32'(tx_count), 0);
    chk("perr_pndng", 32'(pndng), 0);
    tx_write(16'h0777, 1);
    chk("perr_next_head", 32'(D_pop), 32'h0777);
    tx_pop(1);
    chk("perr_next_empty", 32'(pndng), 0);
    chk("perr_sticky", 32'(pop_err), 1);

    for (int i = 0; i < 5; i++) tx_write(16'h0300 + 16'(i), 1);
    chk("pre_rst_count", 32'(tx_count), 5);
    reset = 1; wr_en = 1; wr_data = 16'h0999;
    tick();
    reset = 0; wr_en = 0;
    tx_q.delete(); rx_q.delete();
    chk("mid_rst_count", 32'(tx_count), 0);
    chk("mid_rst_pndng", 32'(pndng), 0);
    chk("mid_rst_pop_err", 32'(pop_err), 0);
    chk("mid_rst_tx_drop", 32'(tx_drop_cnt), 0);
    chk("mid_rst_rx_drop", 32'(rx_drop_cnt), 0);
    chk("mid_rst_D_pop", 32'(D_pop), 0);
    tx_write(16'h0ABC, 1);
    chk("post_rst_head", 32'(D_pop), 32'h0ABC);
    tx_pop(1);
    tick();
    chk("tx_q_left", 32'(tx_q.size()), 0);
    chk("rx_q_left", 32'(rx_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
